// File: rtl/fetch_queue.sv
// fetch_queue: fetch stage between the PC stage and decode; 1-cycle imem reads buffered in a DEPTH-entry FIFO.
// Optional `FETCH_BYPASS_EN forwards a returning instruction straight to decode when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC_ADDRESS,
  output logic        PC_WRITE,
  input  logic        FLUSH,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_RDEN,
  input  logic [31:0] IMEM_DOUT,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic        IR_VALID,
  input  logic        IR_READY
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [31:0]      ir_mem [DEPTH];
  logic [31:0]      pc_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             inflight;
  logic [31:0]      inflight_pc;

  logic             issue;
  logic             head_valid;
  logic             bypass_valid;
  logic             push;
  logic             pop_q;
  logic [CNT_W:0]   credit_used;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^PC_ADDRESS[1:0];

  // Credits count the in-flight read so a returning word always has a free slot.
  assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign issue       = !RESET && !FLUSH && (credit_used < DEPTH_C);

  assign IMEM_ADDR = {PC_ADDRESS[31:2], 2'b00};
  assign IMEM_RDEN = issue;
  assign PC_WRITE  = issue || (FLUSH && !RESET);

  assign head_valid = (count != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_valid = !head_valid && inflight && !FLUSH && !RESET;
`else
  assign bypass_valid = 1'b0;
`endif

  assign IR_VALID = head_valid || bypass_valid;
  assign pop_q    = head_valid && IR_READY;
  // A bypassed word taken by decode this cycle never enters the queue.
  assign push     = inflight && !FLUSH && !(bypass_valid && IR_READY);

  always_comb begin
    IR    = '0;
    IR_PC = '0;
    if (head_valid) begin
      IR    = ir_mem[rd_ptr];
      IR_PC = pc_mem[rd_ptr];
    end else if (bypass_valid) begin
      IR    = IMEM_DOUT;
      IR_PC = inflight_pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (FLUSH) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= issue;
      inflight_pc <= IMEM_ADDR;
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_q) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_q})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RESET) begin
      ir_mem[wr_ptr] <= IMEM_DOUT;
      pc_mem[wr_ptr] <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        CLK;
  logic        RESET;
  logic [31:0] PC_ADDRESS;
  logic        PC_WRITE;
  logic        FLUSH;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RDEN;
  logic [31:0] IMEM_DOUT;
  logic [31:0] IR;
  logic [31:0] IR_PC;
  logic        IR_VALID;
  logic        IR_READY;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] pc_reg;
  logic [31:0] pc_init;
  logic [31:0] flush_target;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .PC_ADDRESS(PC_ADDRESS), .PC_WRITE(PC_WRITE),
    .FLUSH(FLUSH), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDEN(IMEM_RDEN), .IMEM_DOUT(IMEM_DOUT),
    .IR(IR), .IR_PC(IR_PC), .IR_VALID(IR_VALID), .IR_READY(IR_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // PC stage and instruction memory environment
  assign PC_ADDRESS = pc_reg;
  always @(posedge CLK) begin
    if (RESET) pc_reg <= pc_init;
    else if (PC_WRITE) pc_reg <= FLUSH ? flush_target : pc_reg + 32'd4;
  end
  always @(posedge CLK) IMEM_DOUT <= IMEM_RDEN ? (IMEM_ADDR ^ KEY) : $urandom;

  // Reference model: FIFO of PCs still owed to decode plus the one read in flight
  logic [31:0] mq[$];
  bit          m_infl;
  logic [31:0] m_pc;

  function automatic bit m_byp();
`ifdef FETCH_BYPASS_EN
    return (mq.size() == 0) && m_infl && !FLUSH && !RESET;
`else
    return 1'b0;
`endif
  endfunction
  function automatic bit m_valid();
    return (mq.size() != 0) || m_byp();
  endfunction
  function automatic logic [31:0] m_head_pc();
    return (mq.size() != 0) ? mq[0] : m_pc;
  endfunction
  function automatic bit m_issue();
    return !RESET && !FLUSH && ((mq.size() + int'(m_infl)) < DEPTH);
  endfunction

  initial begin : model
    bit iss;
    bit byp;
    m_infl = 1'b0;
    m_pc   = '0;
    forever begin
      @(posedge CLK);
      iss = m_issue();
      byp = m_byp();
      if (RESET || FLUSH) begin
        mq.delete();
        m_infl = 1'b0;
      end else begin
        if (!(byp && IR_READY)) begin
          if ((mq.size() != 0) && IR_READY) void'(mq.pop_front());
          if (m_infl) mq.push_back(m_pc);
        end
        m_infl = iss;
        m_pc   = {PC_ADDRESS[31:2], 2'b00};
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] start);
    RESET = 1'b1; FLUSH = 1'b0; IR_READY = 1'b1; pc_init = start;
    repeat (2) tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; FLUSH = 1'b0; IR_READY = 1'b1; pc_init = 32'h0; flush_target = 32'h0;
    repeat (2) tick();
    @(negedge CLK);
    n_cmp++; if (IR_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_ir_valid: got %0b want 0", IR_VALID); end
    n_cmp++; if (IR !== 32'h0) begin n_bad++; $display("FAIL reset_ir: got %h want 0", IR); end
    n_cmp++; if (IR_PC !== 32'h0) begin n_bad++; $display("FAIL reset_ir_pc: got %h want 0", IR_PC); end
    n_cmp++; if (PC_WRITE !== 1'b0) begin n_bad++; $display("FAIL reset_pc_write: got %0b want 0", PC_WRITE); end
    n_cmp++; if (IMEM_RDEN !== 1'b0) begin n_bad++; $display("FAIL reset_rden: got %0b want 0", IMEM_RDEN); end
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    n_cmp++; if (PC_WRITE !== 1'b1) begin n_bad++; $display("FAIL first_pc_write: got %0b want 1", PC_WRITE); end
    n_cmp++; if (IMEM_RDEN !== 1'b1) begin n_bad++; $display("FAIL first_rden: got %0b want 1", IMEM_RDEN); end
    n_cmp++; if (IMEM_ADDR !== 32'h0) begin n_bad++; $display("FAIL first_addr: got %h want 0", IMEM_ADDR); end
  endtask

  task automatic test_stream();
    int first_iss = -1;
    int first_val = -1;
    int nvalid = 0;
    logic [31:0] exp_pc = 32'h0;
    do_reset(32'h0);
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge CLK);
      if (IMEM_RDEN && first_iss < 0) first_iss = cyc;
      if (IR_VALID && first_val < 0) first_val = cyc;
      if (first_val >= 0) begin
        n_cmp++; if (IR_VALID !== 1'b1) begin n_bad++; $display("FAIL stream_gap: cycle %0d valid %0b want 1", cyc, IR_VALID); end
      end
      if (IR_VALID) begin
        n_cmp++; if (IR_PC !== exp_pc) begin n_bad++; $display("FAIL stream_pc: got %h want %h", IR_PC, exp_pc); end
        n_cmp++; if (IR !== (exp_pc ^ KEY)) begin n_bad++; $display("FAIL stream_ir: got %h want %h", IR, exp_pc ^ KEY); end
        exp_pc += 32'd4;
        nvalid++;
      end
      tick();
    end
    n_cmp++; if ((first_val - first_iss) !== LAT) begin n_bad++; $display("FAIL stream_latency: got %0d want %0d", first_val - first_iss, LAT); end
    n_cmp++; if (nvalid !== 24 - LAT) begin n_bad++; $display("FAIL stream_count: got %0d want %0d", nvalid, 24 - LAT); end
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    int resumed = 0;
    logic [31:0] exp_pc = 32'h0;
    do_reset(32'h0);
    IR_READY = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge CLK);
      if (PC_WRITE) pulses++;
      tick();
    end
    @(negedge CLK);
    n_cmp++; if (pulses !== DEPTH) begin n_bad++; $display("FAIL bp_pulses: got %0d want %0d", pulses, DEPTH); end
    n_cmp++; if (PC_WRITE !== 1'b0) begin n_bad++; $display("FAIL bp_stalled: got %0b want 0", PC_WRITE); end
    n_cmp++; if (IR_PC !== 32'h0) begin n_bad++; $display("FAIL bp_hold_pc: got %h want 0", IR_PC); end
    tick();
    IR_READY = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge CLK);
      if (PC_WRITE) resumed++;
      n_cmp++; if (IR_VALID !== 1'b1) begin n_bad++; $display("FAIL bp_drain_valid: cycle %0d got %0b want 1", cyc, IR_VALID); end
      n_cmp++; if (IR_PC !== exp_pc) begin n_bad++; $display("FAIL bp_drain_pc: got %h want %h", IR_PC, exp_pc); end
      exp_pc += 32'd4;
      tick();
    end
    n_cmp++; if (resumed == 0) begin n_bad++; $display("FAIL bp_resume: got %0d issues want >0", resumed); end
  endtask

  task automatic test_flush_pending();
    bit found = 0;
    bit seen = 0;
    logic [31:0] first_pc = 32'hFFFF_FFFF;
    logic [31:0] first_ir = 32'h0;
    do_reset(32'h0);
    flush_target = 32'h100;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge CLK);
      if (IMEM_RDEN && IMEM_ADDR == 32'h8) found = 1;
      tick();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL fp_issue8: got no issue of 8 want one within 20 cycles"); end
    FLUSH = 1'b1;
    @(negedge CLK);
    n_cmp++; if (PC_WRITE !== 1'b1) begin n_bad++; $display("FAIL fp_pc_write: got %0b want 1", PC_WRITE); end
    n_cmp++; if (IMEM_RDEN !== 1'b0) begin n_bad++; $display("FAIL fp_rden: got %0b want 0", IMEM_RDEN); end
    n_cmp++; if (IR_VALID && IR_PC == 32'h8) begin n_bad++; $display("FAIL fp_stale8: got pc %h want not 8", IR_PC); end
    tick();
    FLUSH = 1'b0;
    @(negedge CLK);
    n_cmp++; if (IR_VALID !== 1'b0) begin n_bad++; $display("FAIL fp_valid_after: got %0b want 0", IR_VALID); end
    n_cmp++; if (IMEM_ADDR !== 32'h100 || IMEM_RDEN !== 1'b1) begin n_bad++; $display("FAIL fp_target_issue: got %h/%0b want 100/1", IMEM_ADDR, IMEM_RDEN); end
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      if (cyc != 0) @(negedge CLK);
      if (IR_VALID) begin seen = 1; first_pc = IR_PC; first_ir = IR; end
      tick();
    end
    n_cmp++; if (first_pc !== 32'h100) begin n_bad++; $display("FAIL fp_next_pc: got %h want 100", first_pc); end
    n_cmp++; if (first_ir !== (32'h100 ^ KEY)) begin n_bad++; $display("FAIL fp_next_ir: got %h want %h", first_ir, 32'h100 ^ KEY); end
  endtask

  task automatic test_flush_full();
    do_reset(32'h0);
    IR_READY = 1'b0;
    repeat (6) tick();
    @(negedge CLK);
    n_cmp++; if (IR_VALID !== 1'b1 || IR_PC !== 32'h0) begin n_bad++; $display("FAIL ff_full_head: got %0b/%h want 1/0", IR_VALID, IR_PC); end
    n_cmp++; if (PC_WRITE !== 1'b0) begin n_bad++; $display("FAIL ff_full_stall: got %0b want 0", PC_WRITE); end
    tick();
    IR_READY = 1'b1; FLUSH = 1'b1; flush_target = 32'h100;
    @(negedge CLK);
    n_cmp++; if (PC_WRITE !== 1'b1 || IMEM_RDEN !== 1'b0) begin n_bad++; $display("FAIL ff_flush_cycle: got pcw %0b rden %0b want 1/0", PC_WRITE, IMEM_RDEN); end
    n_cmp++; if (IR_VALID !== 1'b1) begin n_bad++; $display("FAIL ff_pop_valid: got %0b want 1", IR_VALID); end
    tick();
    FLUSH = 1'b0; IR_READY = 1'b0;
    @(negedge CLK);
    n_cmp++; if (IR_VALID !== 1'b0) begin n_bad++; $display("FAIL ff_empty: got %0b want 0", IR_VALID); end
    n_cmp++; if (IMEM_RDEN !== 1'b1 || IMEM_ADDR !== 32'h100) begin n_bad++; $display("FAIL ff_reissue: got %0b/%h want 1/100", IMEM_RDEN, IMEM_ADDR); end
    tick();
    @(negedge CLK);
    n_cmp++; if (IR_VALID !== (LAT == 1)) begin n_bad++; $display("FAIL ff_n1_valid: got %0b want %0b", IR_VALID, LAT == 1); end
    tick();
    @(negedge CLK);
    n_cmp++; if (IR_VALID !== 1'b1 || IR_PC !== 32'h100) begin n_bad++; $display("FAIL ff_n2_head: got %0b/%h want 1/100", IR_VALID, IR_PC); end
    n_cmp++; if (IR !== (32'h100 ^ KEY)) begin n_bad++; $display("FAIL ff_n2_ir: got %h want %h", IR, 32'h100 ^ KEY); end
  endtask

  task automatic test_bypass_latency();
    do_reset(32'h20);
    IR_READY = 1'b1;
    @(negedge CLK);
    n_cmp++; if (IMEM_RDEN !== 1'b1 || IMEM_ADDR !== 32'h20) begin n_bad++; $display("FAIL bl_issue: got %0b/%h want 1/20", IMEM_RDEN, IMEM_ADDR); end
    tick();
    @(negedge CLK);
    n_cmp++; if (IR_VALID !== (LAT == 1)) begin n_bad++; $display("FAIL bl_n1_valid: got %0b want %0b", IR_VALID, LAT == 1); end
    if (LAT == 1) begin
      n_cmp++; if (IR_PC !== 32'h20) begin n_bad++; $display("FAIL bl_n1_pc: got %h want 20", IR_PC); end
    end
    tick();
    @(negedge CLK);
    n_cmp++; if (IR_VALID !== 1'b1 || IR_PC !== (LAT == 1 ? 32'h24 : 32'h20)) begin n_bad++; $display("FAIL bl_n2_head: got %0b/%h want 1/%h", IR_VALID, IR_PC, (LAT == 1 ? 32'h24 : 32'h20)); end
    tick();
  endtask

  task automatic test_random();
    do_reset({$urandom_range(0, 32'hFFFF), 2'b00});
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge CLK);
      n_cmp++; if (IR_VALID !== m_valid()) begin n_bad++; $display("FAIL rnd_valid: cycle %0d got %0b want %0b", cyc, IR_VALID, m_valid()); end
      if (m_valid()) begin
        n_cmp++; if (IR_PC !== m_head_pc()) begin n_bad++; $display("FAIL rnd_pc: cycle %0d got %h want %h", cyc, IR_PC, m_head_pc()); end
        n_cmp++; if (IR !== (m_head_pc() ^ KEY)) begin n_bad++; $display("FAIL rnd_ir: cycle %0d got %h want %h", cyc, IR, m_head_pc() ^ KEY); end
      end
      n_cmp++; if (IMEM_RDEN !== m_issue()) begin n_bad++; $display("FAIL rnd_rden: cycle %0d got %0b want %0b", cyc, IMEM_RDEN, m_issue()); end
      n_cmp++; if (PC_WRITE !== (m_issue() || (FLUSH && !RESET))) begin n_bad++; $display("FAIL rnd_pc_write: cycle %0d got %0b want %0b", cyc, PC_WRITE, m_issue() || (FLUSH && !RESET)); end
      if (m_issue()) begin
        n_cmp++; if (IMEM_ADDR !== {PC_ADDRESS[31:2], 2'b00}) begin n_bad++; $display("FAIL rnd_addr: cycle %0d got %h want %h", cyc, IMEM_ADDR, {PC_ADDRESS[31:2], 2'b00}); end
      end
      tick();
      IR_READY     = ($urandom_range(0, 9) < 7);
      FLUSH        = ($urandom_range(0, 19) == 0);
      RESET        = ($urandom_range(0, 99) == 0);
      flush_target = $urandom;
      pc_init      = $urandom;
    end
    RESET = 1'b0; FLUSH = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; IR_READY = 1'b1; pc_init = '0; flush_target = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_pending();
    test_flush_full();
    test_bypass_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
